// File: rtl/vuvxu_bank_issue_seq_if.sv
// Command and bank-issue signal bundle for vuvxu_bank_issue_seq.
// master: the sequencer side; slave: the command source / bank-chain side.
interface vuvxu_bank_issue_seq_if;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [10:0] cmd_vlen;
  logic [7:0]  cmd_raddr;
  logic [7:0]  cmd_waddr;
  logic [10:0] cmd_fn;
  logic [64:0] cmd_imm;

  logic        out_ren;
  logic        out_rlast;
  logic [2:0]  out_rcnt;
  logic [7:0]  out_raddr;
  logic [1:0]  out_roplen;
  logic [3:0]  out_rblen;
  logic        out_wen;
  logic        out_wlast;
  logic [2:0]  out_wcnt;
  logic [7:0]  out_waddr;
  logic [2:0]  out_wsel;

  logic        out_viu_val;
  logic [10:0] out_viu_fn;
  logic [10:0] out_viu_utidx;
  logic [64:0] out_viu_imm;

  logic        done;
  logic        busy;

  modport master (
    input  cmd_val, cmd_vlen, cmd_raddr, cmd_waddr, cmd_fn, cmd_imm,
    output cmd_rdy,
    output out_ren, out_rlast, out_rcnt, out_raddr, out_roplen, out_rblen,
    output out_wen, out_wlast, out_wcnt, out_waddr, out_wsel,
    output out_viu_val, out_viu_fn, out_viu_utidx, out_viu_imm,
    output done, busy
  );

  modport slave (
    output cmd_val, cmd_vlen, cmd_raddr, cmd_waddr, cmd_fn, cmd_imm,
    input  cmd_rdy,
    input  out_ren, out_rlast, out_rcnt, out_raddr, out_roplen, out_rblen,
    input  out_wen, out_wlast, out_wcnt, out_waddr, out_wsel,
    input  out_viu_val, out_viu_fn, out_viu_utidx, out_viu_imm,
    input  done, busy
  );
endinterface

// File: rtl/vuvxu_bank_issue_seq.sv
// Bank issue sequencer: splits a vector command into 8-element read groups, writes follow 2 cycles later.
// Optional performance counters enabled by defining VUVXU_SEQ_PERFCNT_EN.
module vuvxu_bank_issue_seq (
  input  logic clk,
  input  logic reset,
  vuvxu_bank_issue_seq_if.master bus
`ifdef VUVXU_SEQ_PERFCNT_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_elems
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state;
  logic [7:0]  raddr_q;
  logic [7:0]  waddr_q;
  logic [10:0] fn_q;
  logic [64:0] imm_q;
  logic [11:0] rem_q;
  logic [7:0]  g_q;

  // Write delay line: stage 1 captured on the read cycle, stage 2 drives the write port.
  logic        s1_v, s1_last, s2_v, s2_last;
  logic [2:0]  s1_cnt, s2_cnt;
  logic [7:0]  s1_addr, s2_addr;

  logic        issue;
  logic        last;
  logic        accept;
  logic [2:0]  rcnt;
  logic [3:0]  n;

  assign issue  = (state == ST_ISSUE);
  assign last   = (rem_q <= 12'd8);
  assign rcnt   = (rem_q >= 12'd8) ? 3'd7 : (rem_q[2:0] - 3'd1);
  assign n      = {1'b0, rcnt} + 4'd1;
  assign accept = bus.cmd_val && bus.cmd_rdy;

  // cmd_rdy is gated by reset so it stays low while reset is held.
  assign bus.cmd_rdy = (state == ST_IDLE) && reset;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = s2_v && s2_last;

  assign bus.out_ren       = issue;
  assign bus.out_rlast     = issue && last;
  assign bus.out_rcnt      = issue ? rcnt : '0;
  assign bus.out_raddr     = issue ? (raddr_q + g_q) : '0;
  assign bus.out_roplen    = '0;
  assign bus.out_rblen     = issue ? 4'b0001 : '0;
  assign bus.out_viu_val   = issue;
  assign bus.out_viu_fn    = issue ? fn_q : '0;
  assign bus.out_viu_utidx = issue ? {g_q, 3'b000} : '0;
  assign bus.out_viu_imm   = issue ? imm_q : '0;

  assign bus.out_wen   = s2_v;
  assign bus.out_wlast = s2_last;
  assign bus.out_wcnt  = s2_cnt;
  assign bus.out_waddr = s2_addr;
  assign bus.out_wsel  = '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      raddr_q <= '0;
      waddr_q <= '0;
      fn_q    <= '0;
      imm_q   <= '0;
      rem_q   <= '0;
      g_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            raddr_q <= bus.cmd_raddr;
            waddr_q <= bus.cmd_waddr;
            fn_q    <= bus.cmd_fn;
            imm_q   <= bus.cmd_imm;
            rem_q   <= {1'b0, bus.cmd_vlen} + 12'd1;
            g_q     <= '0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rem_q <= rem_q - {8'd0, n};
          g_q   <= g_q + 8'd1;
          if (last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (s2_v && s2_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_cnt  <= '0;
      s1_addr <= '0;
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      s2_cnt  <= '0;
      s2_addr <= '0;
    end else begin
      s1_v    <= issue;
      s1_last <= issue && last;
      s1_cnt  <= issue ? rcnt : '0;
      s1_addr <= issue ? (waddr_q + g_q) : '0;
      s2_v    <= s1_v;
      s2_last <= s1_last;
      s2_cnt  <= s1_cnt;
      s2_addr <= s1_addr;
    end
  end

`ifdef VUVXU_SEQ_PERFCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cycles <= '0;
      perf_elems  <= '0;
    end else begin
      if (bus.busy) perf_cycles <= perf_cycles + 32'd1;
      if (issue)    perf_elems  <= perf_elems + {28'd0, n};
    end
  end
`endif

endmodule

// File: tb/tb_vuvxu_bank_issue_seq.sv
// Self-checking bench for vuvxu_bank_issue_seq: directed scenarios plus randomized commands vs a group-list model.
module tb_vuvxu_bank_issue_seq;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  vuvxu_bank_issue_seq_if bus();

`ifdef VUVXU_SEQ_PERFCNT_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_elems;
  vuvxu_bank_issue_seq dut (.clk(clk), .reset(reset), .bus(bus),
                            .perf_cycles(perf_cycles), .perf_elems(perf_elems));
`else
  vuvxu_bank_issue_seq dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1);
  end

  function automatic logic [125:0] obs();
    return {bus.cmd_rdy, bus.busy, bus.done,
            bus.out_ren, bus.out_rlast, bus.out_rcnt, bus.out_raddr, bus.out_roplen, bus.out_rblen,
            bus.out_wen, bus.out_wlast, bus.out_wcnt, bus.out_waddr, bus.out_wsel,
            bus.out_viu_val, bus.out_viu_fn, bus.out_viu_utidx, bus.out_viu_imm};
  endfunction

  // Expected outputs c cycles after acceptance: group k is read in cycle k and written in cycle k+2.
  function automatic logic [125:0] exp_vec(input int c, input logic [10:0] vlen,
                                           input logic [7:0] ra, input logic [7:0] wa,
                                           input logic [10:0] fn, input logic [64:0] imm);
    int ne = int'(vlen) + 1;
    int gt = (ne + 7) / 8;
    int kr = c;
    int kw = c - 2;
    logic rd = (kr < gt);
    logic wr = (kw >= 0) && (kw < gt);
    int nr = rd ? (((ne - 8*kr) < 8) ? (ne - 8*kr) : 8) : 1;
    int nw = wr ? (((ne - 8*kw) < 8) ? (ne - 8*kw) : 8) : 1;
    logic rl = rd && (kr == gt - 1);
    logic wl = wr && (kw == gt - 1);
    logic [2:0]  rc = rd ? 3'(nr - 1) : 3'd0;
    logic [2:0]  wc = wr ? 3'(nw - 1) : 3'd0;
    logic [7:0]  rad = rd ? 8'(int'(ra) + kr) : 8'd0;
    logic [7:0]  wad = wr ? 8'(int'(wa) + kw) : 8'd0;
    logic [10:0] ut = rd ? 11'(8*kr) : 11'd0;
    return {(c >= gt + 2), (c <= gt + 1), wl,
            rd, rl, rc, rad, 2'b00, (rd ? 4'b0001 : 4'b0000),
            wr, wl, wc, wad, 3'b000,
            rd, (rd ? fn : 11'd0), ut, (rd ? imm : 65'd0)};
  endfunction

  task automatic drive_cmd(input logic v, input logic [10:0] vlen, input logic [7:0] ra,
                           input logic [7:0] wa, input logic [10:0] fn, input logic [64:0] imm);
    bus.cmd_val   = v;
    bus.cmd_vlen  = vlen;
    bus.cmd_raddr = ra;
    bus.cmd_waddr = wa;
    bus.cmd_fn    = fn;
    bus.cmd_imm   = imm;
  endtask

  function automatic logic [64:0] rnd_imm();
    return {1'($urandom), $urandom, $urandom};
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the first idle cycle after done.
  task automatic run_cmd(input string name, input logic [10:0] vlen, input logic [7:0] ra,
                         input logic [7:0] wa, input logic [10:0] fn, input logic [64:0] imm,
                         input bit hold, input logic [10:0] nvlen, input logic [7:0] nra,
                         input logic [7:0] nwa, input logic [10:0] nfn, input logic [64:0] nimm);
    int gt = (int'(vlen) + 8) / 8;
    drive_cmd(1'b1, vlen, ra, wa, fn, imm);
    n_checks++;
    if (bus.cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: cmd_rdy=%b required 1", name, bus.cmd_rdy);
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) drive_cmd(1'b1, nvlen, nra, nwa, nfn, nimm);
    else      drive_cmd(1'b0, 11'($urandom), 8'($urandom), 8'($urandom), 11'($urandom), rnd_imm());
    for (int c = 0; c <= gt + 2; c++) begin
      n_checks++;
      if (obs() !== exp_vec(c, vlen, ra, wa, fn, imm)) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h required %h", name, c, obs(), exp_vec(c, vlen, ra, wa, fn, imm));
      end
      if (c < gt + 2) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_cmd(1'b1, 11'd5, 8'h12, 8'h34, 11'h7ff, '1);
    #1;
    n_checks++;
    if (obs() !== 126'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", obs());
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs() !== 126'd0) begin
      n_fail++;
      $display("FAIL reset_held: got %h required 0", obs());
    end
    bus.cmd_val = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs() !== exp_vec(1000, 11'd0, 8'd0, 8'd0, 11'd0, 65'd0)) begin
      n_fail++;
      $display("FAIL reset_release: got %h required %h", obs(), exp_vec(1000, 11'd0, 8'd0, 8'd0, 11'd0, 65'd0));
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_cmd("vlen19", 11'd19, 8'h10, 8'h40, 11'h2a5, 65'h1_dead_beef_cafe_f00d, 1'b0,
            '0, '0, '0, '0, '0);
  endtask

  task automatic test_single();
    run_cmd("vlen0", 11'd0, 8'h33, 8'h77, 11'h155, 65'h0_0000_0000_0000_0001, 1'b0,
            '0, '0, '0, '0, '0);
  endtask

  task automatic test_wrap();
    run_cmd("wrap", 11'd15, 8'hff, 8'hfe, 11'h001, 65'h1_0000_0000_0000_0000, 1'b0,
            '0, '0, '0, '0, '0);
  endtask

  task automatic test_hold();
    run_cmd("hold_first", 11'd10, 8'h20, 8'h30, 11'h111, 65'h0_1234_5678_9abc_def0, 1'b1,
            11'd26, 8'hf8, 8'h05, 11'h6cc, 65'h1_ffff_0000_ffff_0000);
    run_cmd("hold_second", 11'd26, 8'hf8, 8'h05, 11'h6cc, 65'h1_ffff_0000_ffff_0000, 1'b0,
            '0, '0, '0, '0, '0);
  endtask

  task automatic test_reset_mid();
    drive_cmd(1'b1, 11'd63, 8'h80, 8'h90, 11'h3c3, 65'h0_aaaa_5555_aaaa_5555);
    @(posedge clk);
    @(negedge clk);
    drive_cmd(1'b0, '0, '0, '0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (obs() !== exp_vec(c, 11'd63, 8'h80, 8'h90, 11'h3c3, 65'h0_aaaa_5555_aaaa_5555)) begin
        n_fail++;
        $display("FAIL rstmid_pre cycle %0d: got %h required %h", c, obs(),
                 exp_vec(c, 11'd63, 8'h80, 8'h90, 11'h3c3, 65'h0_aaaa_5555_aaaa_5555));
      end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 126'd0) begin
      n_fail++;
      $display("FAIL rstmid_assert: got %h required 0", obs());
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec(1000, 11'd0, 8'd0, 8'd0, 11'd0, 65'd0)) begin
        n_fail++;
        $display("FAIL rstmid_after cycle %0d: got %h required %h", c, obs(),
                 exp_vec(1000, 11'd0, 8'd0, 8'd0, 11'd0, 65'd0));
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] vl, nvl;
    logic [7:0]  ra, wa, nra, nwa;
    logic [10:0] fn, nfn;
    logic [64:0] im, nim;
    nvl = 11'($urandom_range(0, 40));
    nra = 8'($urandom); nwa = 8'($urandom); nfn = 11'($urandom); nim = rnd_imm();
    for (int i = 0; i < 25; i++) begin
      vl = nvl; ra = nra; wa = nwa; fn = nfn; im = nim;
      nvl = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 40));
      nra = 8'($urandom); nwa = 8'($urandom); nfn = 11'($urandom); nim = rnd_imm();
      run_cmd($sformatf("rand%0d", i), vl, ra, wa, fn, im, 1'($urandom), nvl, nra, nwa, nfn, nim);
    end
    bus.cmd_val = 1'b0;
  endtask

`ifdef VUVXU_SEQ_PERFCNT_EN
  task automatic test_perf();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_cmd("perf_cmd", 11'd19, 8'h01, 8'h02, 11'h003, 65'd4, 1'b0, '0, '0, '0, '0, '0);
    n_checks++;
    if (perf_elems !== 32'd20) begin
      n_fail++;
      $display("FAIL perf_elems: got %0d required 20", perf_elems);
    end
    n_checks++;
    if (perf_cycles !== 32'd5) begin
      n_fail++;
      $display("FAIL perf_cycles: got %0d required 5", perf_cycles);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_single();
    test_wrap();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef VUVXU_SEQ_PERFCNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vuvxu_bank_issue_seq.md
VUVXU_BANK_ISSUE_SEQ -- requirements
Module: vuvxu_bank_issue_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: cmd_val  in  1  command valid; cmd_rdy  out  1  command accepted when cmd_val&cmd_rdy.
REQ-003 SHALL have ports: cmd_vlen  in  11  element count minus 1 (1..2048 elements); cmd_raddr/cmd_waddr  in  8  bank-local base rows; cmd_fn  in  11  VIU function; cmd_imm  in  65  immediate.
REQ-004 SHALL have ports: out_ren, out_rlast  out  1; out_rcnt  out  3; out_raddr  out  8; out_roplen  out  2; out_rblen  out  4; out_wen, out_wlast  out  1; out_wcnt  out  3; out_waddr  out  8; out_wsel  out  3 (first-bank chain inputs).
REQ-005 SHALL have ports: out_viu_val  out  1; out_viu_fn  out  11; out_viu_utidx  out  11; out_viu_imm  out  65.
REQ-006 SHALL have ports: done  out  1  one-cycle pulse when last write group issued; busy  out  1  state != IDLE.

Function
REQ-007 SHALL have states IDLE, ISSUE, DRAIN; IDLE->ISSUE on cmd accept; ISSUE->DRAIN after last group issued; DRAIN->IDLE when write delay line empty.
REQ-008 SHALL assert cmd_rdy only in IDLE; commands presented in other states SHALL wait, not be dropped.
REQ-009 SHALL, on accept, latch all cmd_* fields and set remaining = cmd_vlen+1, group index g = 0.
REQ-010 SHALL in ISSUE emit exactly one group per cycle: n = min(remaining, 8); out_ren=1, out_viu_val=1, out_rcnt=n-1, out_raddr=raddr_base+g, out_viu_utidx=8*g, out_rlast=(remaining<=8).
REQ-011 SHALL drive out_roplen=2'b00, out_rblen=4'b0001, out_wsel=3'd0, out_viu_fn/out_viu_imm = latched values during ISSUE.
REQ-012 SHALL after each group subtract n from remaining and increment g (8-bit row add wraps mod 256).
REQ-013 SHALL issue the write for a group exactly 2 cycles after its read: out_wen=1, out_wcnt=same n-1, out_waddr=waddr_base+g, out_wlast=that group's rlast, via a 2-stage delay line.
REQ-014 SHALL pulse done in the cycle out_wen&out_wlast; DRAIN->IDLE on that same edge.
REQ-015 SHALL drive all out_* enables/valids to 0 and data fields to 0 whenever no group is issued.
REQ-016 SHALL, for vlen=0 (one element), issue one group with rcnt=0, rlast=1, and done 2 cycles later.
REQ-017 SHALL allow a new command accepted in the cycle after done (no back-to-back overlap).

Reset
REQ-018 SHALL on reset low immediately force state IDLE, delay line empty, all registers 0, cmd_rdy=0 while asserted, all outputs 0.
REQ-019 SHALL abandon an in-flight command on reset mid-operation; no done pulse SHALL follow.
REQ-020 SHALL assert cmd_rdy in the first cycle after reset deasserts.

Configuration
REQ-021 SHALL, with VUVXU_SEQ_PERFCNT_EN defined, add output perf_cycles (32) counting cycles with busy=1 and perf_elems (32) adding n per issued group, both cleared only by reset, wrapping at 2^32.
REQ-022 SHALL, without VUVXU_SEQ_PERFCNT_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-023 SHALL cover: cmd vlen=19, raddr=0x10, waddr=0x40 -> reads rcnt 7,7,3 at rows 0x10,0x11,0x12, utidx 0,8,16, rlast on third; writes rows 0x40..0x42 2 cycles later; done with third write.
REQ-024 SHALL cover: vlen=0 -> single read rcnt=0 rlast=1, write 2 cycles later, done same cycle, cmd_rdy next cycle.
REQ-025 SHALL cover: raddr=0xFF, vlen=15 -> rows 0xFF then 0x00 (wrap).
REQ-026 SHALL cover: cmd_val held high during ISSUE/DRAIN with new fields -> not accepted until IDLE, then issued correctly.
REQ-027 SHALL cover: reset asserted during ISSUE of vlen=63 -> all outputs 0 same cycle, no done, cmd_rdy=1 first cycle after release.
REQ-028 SHALL cover: with VUVXU_SEQ_PERFCNT_EN, vlen=19 command -> perf_elems=20, perf_cycles=5.
